// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - three-state issue/writeback sequencer driving an external registered ALU
module alu_issue #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inst_valid,
  input  logic [31:0]  inst_in,
  output logic         inst_ready,
  output logic [N-1:0] alu_rs1,
  output logic [N-1:0] alu_rs2,
  output logic [31:0]  alu_inst,
  input  logic [N-1:0] alu_res,
  input  logic         alu_zf,
  output logic         wb_valid,
  output logic [4:0]   wb_rd,
  output logic [N-1:0] wb_data,
  output logic         wb_zf,
  output logic         illegal,
  input  logic [4:0]   dbg_addr,
  output logic [N-1:0] dbg_data,
  output logic [31:0]  retired
);

  typedef enum logic [1:0] {IDLE, ISSUE, WB} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  regs_q [32];
  logic [4:0]    rd_q;
  logic [31:0]   alu_inst_q;
  logic [N-1:0]  rs1_q, rs2_q;
  logic          illegal_q;
  logic [31:0]   retired_q;

  logic          opcode_legal;
  logic [4:0]    rs1_addr, rs2_addr;
  logic [N-1:0]  rs1_val, rs2_val;

  assign opcode_legal = (inst_in[6:0] == 7'b0110011) || (inst_in[6:0] == 7'b0010011);
  assign rs1_addr     = inst_in[19:15];
  assign rs2_addr     = inst_in[24:20];
  assign rs1_val      = (rs1_addr == 5'd0) ? '0 : regs_q[rs1_addr];
  assign rs2_val      = (rs2_addr == 5'd0) ? '0 : regs_q[rs2_addr];

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (inst_valid && opcode_legal) state_d = ISSUE;
      ISSUE:   state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    inst_ready = (state_q == IDLE) && !rst;
    wb_valid   = (state_q == WB) && !rst;
    wb_rd      = wb_valid ? rd_q    : 5'd0;
    wb_data    = wb_valid ? alu_res : '0;
    wb_zf      = wb_valid ? alu_zf  : 1'b0;
  end

  // Operands are latched on the accept edge so the ALU sees them throughout ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      rd_q       <= '0;
      alu_inst_q <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      illegal_q  <= 1'b0;
      retired_q  <= '0;
    end else begin
      illegal_q <= 1'b0;
      if (state_q == IDLE && inst_valid) begin
        if (opcode_legal) begin
          rd_q       <= inst_in[11:7];
          alu_inst_q <= inst_in;
          rs1_q      <= rs1_val;
          rs2_q      <= rs2_val;
        end else begin
          illegal_q  <= 1'b1;
        end
      end
      if (state_q == WB) begin
        if (rd_q != 5'd0) regs_q[rd_q] <= alu_res;
        retired_q <= retired_q + 32'd1;
      end
    end
  end

  assign alu_inst = alu_inst_q;
  assign alu_rs1  = rs1_q;
  assign alu_rs2  = rs2_q;
  assign illegal  = illegal_q;
  assign retired  = retired_q;
  assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - scoreboard bench for alu_issue with a registered add/sub ALU stub
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid;
  logic [31:0] inst_in;
  logic        inst_ready;
  logic [31:0] alu_rs1, alu_rs2, alu_inst;
  logic [31:0] alu_res;
  logic        alu_zf;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_zf;
  logic        illegal;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [31:0] retired;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        zf;
  } wb_t;

  wb_t exp_q[$];

  always #5 clk = ~clk;

  alu_issue #(.N(32)) dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_in(inst_in),
    .inst_ready(inst_ready), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
    .alu_inst(alu_inst), .alu_res(alu_res), .alu_zf(alu_zf),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_zf(wb_zf),
    .illegal(illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .retired(retired)
  );

  function automatic logic [31:0] alu_f(input logic [31:0] i, input logic [31:0] a,
                                        input logic [31:0] b);
    if (i[6:0] == 7'b0010011) return a + {{20{i[31]}}, i[31:20]};
    else if (i[30])           return a - b;
    else                      return a + b;
  endfunction

  // Registered ALU: result appears one clock after the operands.
  always @(posedge clk) begin
    alu_res <= alu_f(alu_inst, alu_rs1, alu_rs2);
    alu_zf  <= (alu_f(alu_inst, alu_rs1, alu_rs2) == 32'd0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    wb_t e;
    if (wb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL wb_unexpected: got wb_valid=1 rd=%0d data=0x%0h, expected none",
                 wb_rd, wb_data);
      end else begin
        e = exp_q.pop_front();
        check("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
        check("wb_data", wb_data, e.data);
        check("wb_zf", {31'd0, wb_zf}, {31'd0, e.zf});
      end
    end
  end

  task automatic dbg(input logic [4:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    check($sformatf("dbg_x%0d", a), dbg_data, exp);
  endtask

  task automatic issue(input logic [31:0] inst, input logic [4:0] rd,
                       input logic [31:0] data, input logic zf);
    int t = 0;
    while (inst_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (inst_ready !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_timeout: got inst_ready=%b, expected 1", inst_ready);
      return;
    end
    exp_q.push_back({rd, data, zf});
    inst_valid = 1'b1;
    inst_in    = inst;
    @(negedge clk);
    inst_valid = 1'b0;
    inst_in    = 32'd0;
    check("issue_ready", {31'd0, inst_ready}, 32'd0);
    check("issue_alu_inst", alu_inst, inst);
    check("issue_no_wb", {31'd0, wb_valid}, 32'd0);
    @(negedge clk);
    check("wb_at_accept_plus2", {31'd0, wb_valid}, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    rst        = 1'b1;
    inst_valid = 1'b0;
    inst_in    = 32'd0;
    dbg_addr   = 5'd0;
    repeat (2) @(negedge clk);
    check("rst_ready_low", {31'd0, inst_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {31'd0, inst_ready}, 32'd1);
    check("post_rst_retired", retired, 32'd0);
    check("post_rst_illegal", {31'd0, illegal}, 32'd0);
    check("post_rst_alu_inst", alu_inst, 32'd0);

    issue(32'h00500093, 5'd1, 32'd5, 1'b0);
    dbg(5'd1, 32'd5);
    check("retired_1", retired, 32'd1);

    issue(32'h00700113, 5'd2, 32'd7, 1'b0);
    issue(32'h002081B3, 5'd3, 32'd12, 1'b0);
    dbg(5'd3, 32'd12);
    check("retired_3", retired, 32'd3);

    issue(32'h40108233, 5'd4, 32'd0, 1'b1);
    dbg(5'd4, 32'd0);
    dbg(5'd1, 32'd5);

    issue(32'h00700013, 5'd0, 32'd7, 1'b0);
    dbg(5'd0, 32'd0);
    check("retired_5", retired, 32'd5);

    inst_valid = 1'b1;
    inst_in    = 32'h00000073;
    @(negedge clk);
    inst_valid = 1'b0;
    inst_in    = 32'd0;
    check("illegal_pulse", {31'd0, illegal}, 32'd1);
    check("illegal_ready", {31'd0, inst_ready}, 32'd1);
    @(negedge clk);
    check("illegal_cleared", {31'd0, illegal}, 32'd0);
    check("illegal_retired", retired, 32'd5);

    inst_valid = 1'b1;
    inst_in    = 32'h00900293;
    @(negedge clk);
    inst_valid = 1'b0;
    inst_in    = 32'd0;
    check("abort_issue_alu_inst", alu_inst, 32'h00900293);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ready_in_rst", {31'd0, inst_ready}, 32'd0);
    check("abort_no_wb", {31'd0, wb_valid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready_after", {31'd0, inst_ready}, 32'd1);
    check("abort_retired", retired, 32'd0);
    check("abort_alu_inst_clr", alu_inst, 32'd0);
    dbg(5'd5, 32'd0);
    dbg(5'd1, 32'd0);

    issue(32'h00900293, 5'd5, 32'd9, 1'b0);
    dbg(5'd5, 32'd9);
    check("retired_after_rst", retired, 32'd1);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter N, default 32, meaning datapath and register width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have ports inst_valid input 1 and inst_in input 32: instruction offered by the upstream fetch stage.
REQ-005 SHALL have port inst_ready  output  1  high when an instruction is accepted this cycle.
REQ-006 SHALL have ports alu_rs1, alu_rs2 output N and alu_inst output 32: operands and instruction driven to the ALU.
REQ-007 SHALL have ports alu_res input N and alu_zf input 1: the ALU's registered result and zero flag, valid one clock after the operands are presented.
REQ-008 SHALL have ports wb_valid output 1, wb_rd output 5, wb_data output N, wb_zf output 1: writeback report.
REQ-009 SHALL have port illegal  output  1  one-cycle pulse on rejecting an unsupported opcode.
REQ-010 SHALL have ports dbg_addr input 5 and dbg_data output N: combinational register-file read.
REQ-011 SHALL have port retired  output 32  count of completed instructions.

Function
REQ-012 SHALL contain a 32 x N register file; x0 reads as 0 at all times and is never written.
REQ-013 SHALL run a 3-state FSM: IDLE, ISSUE, WB.
REQ-014 IDLE: inst_ready=1; on inst_valid=1, inst_in is captured into an internal instruction register.
REQ-015 IDLE acceptance: opcode inst_in[6:0] of 0110011 (R-type) or 0010011 (I-type) SHALL go to ISSUE; any other opcode SHALL pulse illegal for the next cycle and remain in IDLE with no register-file write.
REQ-016 ISSUE: alu_inst = captured instruction, alu_rs1 = regs[inst[19:15]], alu_rs2 = regs[inst[24:20]]; inst_ready=0; next state WB.
REQ-017 WB: alu_res and alu_zf SHALL be sampled; regs[inst[11:7]] <= alu_res unless rd=0; wb_valid=1 for exactly this cycle, wb_rd=rd, wb_data=alu_res, wb_zf=alu_zf; next state IDLE.
REQ-018 alu_inst, alu_rs1, alu_rs2 SHALL hold their ISSUE values through WB and until the next ISSUE.
REQ-019 Throughput SHALL be one instruction per 3 cycles; inst_ready=0 in ISSUE and WB, so no hazard or forwarding logic is needed.
REQ-020 An instruction with rd=0 SHALL still produce wb_valid with wb_rd=0 and wb_data=alu_res, and SHALL increment retired.
REQ-021 retired SHALL increment by 1 on each WB cycle and wrap from 0xFFFFFFFF to 0; illegal instructions SHALL NOT count.
REQ-022 dbg_data SHALL equal regs[dbg_addr] combinationally and SHALL show 0 for dbg_addr=0; a write in WB is visible on the following cycle.
REQ-023 When inst_valid=0 in IDLE, the FSM SHALL stay in IDLE with no outputs changing except inst_ready=1.

Reset
REQ-024 rst=1 at a clock edge SHALL force IDLE, clear all 32 registers, retired, alu_inst, alu_rs1, alu_rs2, wb_* and illegal to 0, in any state.
REQ-025 Reset asserted during ISSUE or WB SHALL abort the instruction: no register write, no wb_valid, and no retired increment.
REQ-026 inst_ready SHALL be 0 while rst=1 and 1 in the first cycle after rst deasserts.

Verification
REQ-027 ADDI x1,x0,5 (0x00500093) -> wb_valid at accept+2, wb_rd=1, wb_data=5, wb_zf=0; dbg_addr=1 then reads 5; retired=1.
REQ-028 Then ADDI x2,x0,7 (0x00700113) and ADD x3,x1,x2 (0x002081B3) -> wb_data=12 for rd=3; retired=3.
REQ-029 SUB x4,x1,x1 (0x40108233) with x1=5 -> wb_data=0, wb_zf=1, regs[4]=0.
REQ-030 ADDI x0,x0,7 (0x00700013) -> wb_valid=1, wb_rd=0, wb_data=7; dbg_addr=0 still reads 0.
REQ-031 Offer 0x00000073 -> illegal pulses 1 cycle, no wb_valid, retired unchanged, inst_ready stays 1.
REQ-032 Assert rst during the ISSUE cycle of ADDI x5,x0,9 -> no wb_valid, regs[5]=0, retired=0, and inst_ready=1 one cycle after rst deasserts.
